stall_ctrl: RTL and testbench

- Parametrised successor to the single-source data-memory clock stall in the processor top level.
- Arbitrates N_SRC memory-side stall requesters, such as data memory, instruction memory and peripherals.
- Drives a synchronous processor clock enable (proc_ce_o) instead of forcing the clock high.
- Each source's stall length is set by a programmable wait-state count or a done handshake; a timeout watchdog guards the handshake mode, and stall cycles are counted for profiling.

---
 rtl/stall_ctrl_if.sv | 23 ++
 rtl/stall_ctrl.sv | 71 +++++++
 tb/tb_stall_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/stall_ctrl_if.sv
// stall_ctrl_if: request/config inputs and clock-enable/status outputs of the stall controller
interface stall_ctrl_if #(
  parameter int N_SRC  = 2,
  parameter int WAIT_W = 4,
  parameter int CNT_W  = 16
);
  logic [N_SRC-1:0]        req_i;
  logic [N_SRC*WAIT_W-1:0] wait_cfg_i;
  logic [N_SRC-1:0]        done_i;
  logic                    proc_ce_o;
  logic [N_SRC-1:0]        grant_o;
  logic                    busy_o;
  logic                    timeout_o;
  logic [CNT_W-1:0]        stall_cnt_o;
  modport master (
    output req_i, wait_cfg_i, done_i,
    input  proc_ce_o, grant_o, busy_o, timeout_o, stall_cnt_o
  );
  modport slave (
    input  req_i, wait_cfg_i, done_i,
    output proc_ce_o, grant_o, busy_o, timeout_o, stall_cnt_o
  );
endinterface

// File: rtl/stall_ctrl.sv
// stall_ctrl: priority arbiter of memory stall requests driving a registered processor clock enable
module stall_ctrl #(
  parameter int N_SRC   = 2,
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input logic         clk,
  input logic         reset,
  stall_ctrl_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = WAIT_W > TW ? WAIT_W : TW;
  localparam int SW = N_SRC > 1 ? $clog2(N_SRC) : 1;
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RELEASE = 2'd2;
  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic              hs, first, tmo, any, done_k, last, fin;
  logic [N_SRC-1:0]  grant;
  logic [CNT_W-1:0]  scnt;
  logic [SW-1:0]     sel;
  logic [WAIT_W-1:0] field;
  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (bus.req_i[i]) sel = SW'(i);
    any    = |bus.req_i;
    field  = bus.wait_cfg_i[sel*WAIT_W +: WAIT_W];
    done_k = !first && |(bus.done_i & grant);
    last   = cnt == CW'(1);
    fin    = done_k || last;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hs    <= 1'b0;
      first <= 1'b0;
      tmo   <= 1'b0;
      grant <= '0;
      scnt  <= '0;
    end else begin
      scnt <= (state == WAIT && !(&scnt)) ? scnt + 1'b1 : scnt;
      case (state)
        IDLE: if (any && field != '0) begin
          state <= WAIT;
          grant <= N_SRC'(1) << sel;
          hs    <= &field;
          cnt   <= &field ? CW'(TIMEOUT) : CW'(field);
          first <= 1'b1;
        end
        WAIT: begin
          cnt   <= cnt - 1'b1;
          first <= 1'b0;
          if (fin) begin
            state <= RELEASE;
            grant <= '0;
            // an arriving done on the final count still counts as success
            if (hs && !done_k) tmo <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.proc_ce_o   = state != WAIT;
  assign bus.busy_o      = state == WAIT;
  assign bus.grant_o     = grant;
  assign bus.timeout_o   = tmo;
  assign bus.stall_cnt_o = scnt;
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed plus random stimulus checked against a stall-length reference model
module tb_stall_ctrl;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0, checks = 0;
  stall_ctrl_if #(.N_SRC(2), .WAIT_W(4), .CNT_W(4)) bus ();
  stall_ctrl #(.N_SRC(2), .WAIT_W(4), .TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  // reference: a stall is "owner, elapsed cycles, limit", released when elapsed hits limit or done arrives
  bit m_stall = 0, m_rel = 0, m_hs = 0, m_tmo = 0;
  int m_owner = 0, m_elapsed = 0, m_limit = 0, m_scnt = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic [1:0] r, input logic [7:0] w, input logic [1:0] d, input logic rs);
    int wk;
    bit done_ok;
    if (rs) begin
      m_stall = 0; m_rel = 0; m_tmo = 0; m_scnt = 0;
    end else if (m_stall) begin
      m_scnt = m_scnt < 15 ? m_scnt + 1 : 15;
      m_elapsed++;
      done_ok = m_elapsed > 1 && d[m_owner];
      if (done_ok || m_elapsed == m_limit) begin
        m_stall = 0; m_rel = 1;
        if (m_hs && !done_ok) m_tmo = 1;
      end
    end else if (m_rel) m_rel = 0;
    else if (r != 0) begin
      m_owner = r[0] ? 0 : 1;
      wk = m_owner == 0 ? int'(w[3:0]) : int'(w[7:4]);
      if (wk != 0) begin
        m_stall = 1; m_hs = wk == 15; m_limit = m_hs ? TO : wk; m_elapsed = 0;
      end
    end
  endtask
  task automatic cyc(input logic [1:0] r, input logic [7:0] w, input logic [1:0] d, input logic rs);
    @(negedge clk);
    chk("proc_ce", 32'(bus.proc_ce_o), 32'(!m_stall));
    chk("busy", 32'(bus.busy_o), 32'(m_stall));
    chk("grant", 32'(bus.grant_o), m_stall ? 32'(1) << m_owner : 32'd0);
    chk("timeout", 32'(bus.timeout_o), 32'(m_tmo));
    chk("stall_cnt", 32'(bus.stall_cnt_o), 32'(m_scnt));
    bus.req_i = r; bus.wait_cfg_i = w; bus.done_i = d; reset = rs;
    step(r, w, d, rs);
  endtask
  initial begin
    bus.req_i = 2'b11; bus.wait_cfg_i = 8'h33; bus.done_i = 2'b00;
    repeat (2) @(posedge clk);
    repeat (3) cyc(2'b11, 8'h33, 2'b00, 1'b1);
    cyc(2'b00, 8'h33, 2'b00, 1'b0);
    cyc(2'b00, 8'h33, 2'b00, 1'b0);
    chk("idle_after_reset", 32'(bus.proc_ce_o), 32'd1);
    cyc(2'b01, 8'h03, 2'b00, 1'b0);
    repeat (4) cyc(2'b00, 8'h03, 2'b00, 1'b0);
    chk("single_stall_cnt", 32'(bus.stall_cnt_o), 32'd3);
    repeat (8) cyc(2'b11, 8'h42, 2'b00, 1'b0);
    repeat (8) cyc(2'b10, 8'h42, 2'b00, 1'b0);
    cyc(2'b00, 8'h42, 2'b00, 1'b0);
    cyc(2'b01, 8'h0F, 2'b00, 1'b0);
    cyc(2'b00, 8'h0F, 2'b00, 1'b0);
    cyc(2'b00, 8'h0F, 2'b00, 1'b0);
    cyc(2'b00, 8'h0F, 2'b01, 1'b0);
    repeat (3) cyc(2'b00, 8'h0F, 2'b00, 1'b0);
    chk("hs_done_no_timeout", 32'(bus.timeout_o), 32'd0);
    cyc(2'b01, 8'h0F, 2'b00, 1'b0);
    repeat (10) cyc(2'b00, 8'h0F, 2'b00, 1'b0);
    chk("hs_timeout_set", 32'(bus.timeout_o), 32'd1);
    cyc(2'b01, 8'h02, 2'b00, 1'b0);
    repeat (4) cyc(2'b00, 8'h02, 2'b00, 1'b0);
    chk("timeout_sticky", 32'(bus.timeout_o), 32'd1);
    repeat (4) cyc(2'b11, 8'h30, 2'b00, 1'b0);
    chk("zero_wait_no_grant", 32'(bus.grant_o), 32'd0);
    cyc(2'b01, 8'h04, 2'b00, 1'b0);
    repeat (3) cyc(2'b00, 8'h04, 2'b10, 1'b0);
    repeat (3) cyc(2'b00, 8'h04, 2'b00, 1'b0);
    cyc(2'b00, 8'h00, 2'b00, 1'b1);
    repeat (4) begin
      cyc(2'b01, 8'h05, 2'b00, 1'b0);
      repeat (6) cyc(2'b00, 8'h05, 2'b00, 1'b0);
    end
    chk("stall_cnt_saturated", 32'(bus.stall_cnt_o), 32'd15);
    cyc(2'b01, 8'h07, 2'b00, 1'b0);
    cyc(2'b00, 8'h07, 2'b00, 1'b0);
    cyc(2'b00, 8'h07, 2'b00, 1'b0);
    cyc(2'b00, 8'h07, 2'b00, 1'b1);
    cyc(2'b00, 8'h07, 2'b00, 1'b0);
    chk("reset_mid_wait_ce", 32'(bus.proc_ce_o), 32'd1);
    chk("reset_mid_wait_cnt", 32'(bus.stall_cnt_o), 32'd0);
    repeat (600) begin
      logic [7:0] w;
      w = 8'($urandom);
      if ($urandom_range(0, 3) == 0) w[3:0] = 4'hF;
      cyc(2'($urandom), w, ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
          $urandom_range(0, 99) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
